// File: rtl/mem_port_arbiter3.sv
// Round-robin arbiter sharing one downstream memory port among three requesters.
// The grant is held from the IDLE->BUSY edge until the downstream side reports completion.
module mem_port_arbiter3 #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_req,
  input  logic [WIDTH-1:0] i_payload0,
  input  logic [WIDTH-1:0] i_payload1,
  input  logic [WIDTH-1:0] i_payload2,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_payload,
  input  logic             i_out_done,
  output logic [2:0]       o_done,
  output logic [1:0]       o_sel,
  output logic             o_busy,
  output logic             o_dbg_state
);

  // Handshake: requester i raises req[i] with a stable payload and holds both until it
  // sees done[i]. The shared port sees out_valid from grant until out_done; a done pulse
  // is returned in the same cycle as out_done, and the requester drops req the next cycle.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     r_state;
  logic [1:0] r_sel;
  logic [1:0] r_last;
  logic       r_just_done;

  logic [2:0]       w_mask;
  logic [2:0]       w_eligible;
  logic [1:0]       w_pick;
  logic             w_any;
  logic             w_busy;
  logic [2:0]       w_done;
  logic [WIDTH-1:0] w_payload;

  // The requester that just completed still holds req for one cycle; hide it then.
  always_comb begin
    w_mask = 3'b000;
    if (r_just_done) begin
      case (r_last)
        2'd0:    w_mask = 3'b001;
        2'd1:    w_mask = 3'b010;
        default: w_mask = 3'b100;
      endcase
    end
    w_eligible = i_req & ~w_mask;
    w_any      = |w_eligible;
  end

  always_comb begin
    w_pick = 2'd0;
    case (r_last)
      2'd0: begin
        if (w_eligible[1])      w_pick = 2'd1;
        else if (w_eligible[2]) w_pick = 2'd2;
        else                    w_pick = 2'd0;
      end
      2'd1: begin
        if (w_eligible[2])      w_pick = 2'd2;
        else if (w_eligible[0]) w_pick = 2'd0;
        else                    w_pick = 2'd1;
      end
      default: begin
        if (w_eligible[0])      w_pick = 2'd0;
        else if (w_eligible[1]) w_pick = 2'd1;
        else                    w_pick = 2'd2;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_sel       <= 2'd0;
      r_last      <= 2'd2;
      r_just_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_just_done <= 1'b0;
          if (w_any) begin
            r_sel   <= w_pick;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (i_out_done) begin
            r_state     <= IDLE;
            r_last      <= r_sel;
            r_just_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy = (r_state == BUSY);

  always_comb begin
    w_done    = 3'b000;
    w_payload = '0;
    if (w_busy) begin
      case (r_sel)
        2'd0: begin
          w_payload = i_payload0;
          w_done    = {2'b00, i_out_done};
        end
        2'd1: begin
          w_payload = i_payload1;
          w_done    = {1'b0, i_out_done, 1'b0};
        end
        2'd2: begin
          w_payload = i_payload2;
          w_done    = {i_out_done, 2'b00};
        end
        default: begin
          w_payload = '0;
          w_done    = 3'b000;
        end
      endcase
    end
  end

  assign o_out_valid   = w_busy;
  assign o_busy        = w_busy;
  assign o_out_payload = w_payload;
  assign o_done        = w_done;
  assign o_sel         = r_sel;
  assign o_dbg_state   = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Cycle-by-cycle vector bench for mem_port_arbiter3: each record drives one cycle of
// inputs and states the outputs expected during that cycle.
module tb_mem_port_arbiter3;
  localparam int WIDTH = 64;
  localparam int EW    = 7 + WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req;
  logic [WIDTH-1:0] payload0, payload1, payload2;
  logic             out_done;
  logic             o_out_valid;
  logic [WIDTH-1:0] o_out_payload;
  logic [2:0]       o_done;
  logic [1:0]       o_sel;
  logic             o_busy;
  logic             o_dbg_state;

  mem_port_arbiter3 #(.WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_payload0   (payload0),
    .i_payload1   (payload1),
    .i_payload2   (payload2),
    .o_out_valid  (o_out_valid),
    .o_out_payload(o_out_payload),
    .i_out_done   (out_done),
    .o_done       (o_done),
    .o_sel        (o_sel),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       od;
    logic       valid;
    logic [1:0] sel;
    logic [2:0] done;
  } vec_t;

  vec_t             vecs[$];
  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] pay[3];
  int               n_checks = 0;
  int               n_fail   = 0;

  function automatic void add(input logic rst, input logic [2:0] r, input logic od,
                              input logic valid, input logic [1:0] sel, input logic [2:0] done);
    vec_t v;
    v.rst   = rst;
    v.req   = r;
    v.od    = od;
    v.valid = valid;
    v.sel   = sel;
    v.done  = done;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name);
    logic [EW-1:0] exp_w;
    logic [EW-1:0] got;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    exp_w = exp_q.pop_front();
    got   = {o_out_valid, o_busy, o_sel, o_done, o_out_payload};
    if (got !== exp_w || o_dbg_state !== exp_w[EW-2]) begin
      n_fail++;
      $display("FAIL %s: got valid=%b busy=%b sel=%b done=%b payload=%h dbg=%b, expected valid=%b busy=%b sel=%b done=%b payload=%h",
               name, got[EW-1], got[EW-2], got[EW-3 -: 2], got[WIDTH+2:WIDTH], got[WIDTH-1:0], o_dbg_state,
               exp_w[EW-1], exp_w[EW-2], exp_w[EW-3 -: 2], exp_w[WIDTH+2:WIDTH], exp_w[WIDTH-1:0]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = 3'b000;
    out_done = 1'b0;
    payload0 = {$urandom, $urandom};
    payload1 = {$urandom, $urandom};
    payload2 = {$urandom, $urandom};

    // reset / single request to requester 1, including one-cycle mask after its done
    add(1, 3'b000, 0, 0, 2'b00, 3'b000);
    add(0, 3'b010, 0, 0, 2'b00, 3'b000);
    add(0, 3'b010, 0, 1, 2'b01, 3'b000);
    add(0, 3'b010, 0, 1, 2'b01, 3'b000);
    add(0, 3'b010, 1, 1, 2'b01, 3'b010);
    add(0, 3'b010, 0, 0, 2'b01, 3'b000);
    add(0, 3'b000, 0, 0, 2'b01, 3'b000);
    // full contention from reset: grants 0,1,2,0,1,2 with a done every 2 cycles
    add(1, 3'b000, 0, 0, 2'b00, 3'b000);
    add(0, 3'b111, 0, 0, 2'b00, 3'b000);
    add(0, 3'b111, 1, 1, 2'b00, 3'b001);
    add(0, 3'b111, 0, 0, 2'b00, 3'b000);
    add(0, 3'b111, 1, 1, 2'b01, 3'b010);
    add(0, 3'b111, 0, 0, 2'b01, 3'b000);
    add(0, 3'b111, 1, 1, 2'b10, 3'b100);
    add(0, 3'b111, 0, 0, 2'b10, 3'b000);
    add(0, 3'b111, 1, 1, 2'b00, 3'b001);
    add(0, 3'b111, 0, 0, 2'b00, 3'b000);
    add(0, 3'b111, 1, 1, 2'b01, 3'b010);
    add(0, 3'b111, 0, 0, 2'b01, 3'b000);
    add(0, 3'b111, 1, 1, 2'b10, 3'b100);
    // wrap from last=2 with req=101: grant 0, then 2, then 0
    add(0, 3'b101, 0, 0, 2'b10, 3'b000);
    add(0, 3'b101, 1, 1, 2'b00, 3'b001);
    add(0, 3'b101, 0, 0, 2'b00, 3'b000);
    add(0, 3'b101, 1, 1, 2'b10, 3'b100);
    add(0, 3'b101, 0, 0, 2'b10, 3'b000);
    add(0, 3'b101, 1, 1, 2'b00, 3'b001);
    // hold requester 1 while others toggle (one cycle of it dropping req too)
    add(0, 3'b010, 0, 0, 2'b00, 3'b000);
    add(0, 3'b111, 0, 1, 2'b01, 3'b000);
    add(0, 3'b011, 0, 1, 2'b01, 3'b000);
    add(0, 3'b110, 0, 1, 2'b01, 3'b000);
    add(0, 3'b101, 0, 1, 2'b01, 3'b000);
    add(0, 3'b111, 0, 1, 2'b01, 3'b000);
    add(0, 3'b111, 1, 1, 2'b01, 3'b010);
    // stray out_done in IDLE
    add(0, 3'b000, 1, 0, 2'b01, 3'b000);
    add(0, 3'b000, 1, 0, 2'b01, 3'b000);
    // requester 0 lingers one cycle after done: masked once, then re-granted
    add(0, 3'b001, 0, 0, 2'b01, 3'b000);
    add(0, 3'b001, 1, 1, 2'b00, 3'b001);
    add(0, 3'b001, 0, 0, 2'b00, 3'b000);
    add(0, 3'b001, 0, 0, 2'b00, 3'b000);
    add(0, 3'b001, 0, 1, 2'b00, 3'b000);
    add(0, 3'b001, 1, 1, 2'b00, 3'b001);
    // async reset while requester 2 is granted, then req=111 grants 0
    add(0, 3'b100, 0, 0, 2'b00, 3'b000);
    add(0, 3'b100, 0, 1, 2'b10, 3'b000);
    add(1, 3'b100, 1, 0, 2'b00, 3'b000);
    add(0, 3'b111, 0, 0, 2'b00, 3'b000);
    add(0, 3'b111, 0, 1, 2'b00, 3'b000);
    add(0, 3'b111, 1, 1, 2'b00, 3'b001);
    add(0, 3'b000, 0, 0, 2'b00, 3'b000);

    #2;
    exp_q.push_back({1'b0, 1'b0, 2'b00, 3'b000, {WIDTH{1'b0}}});
    check_out("reset_state");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) pay[k] = {$urandom, $urandom};
      reset    = vecs[i].rst;
      req      = vecs[i].req;
      out_done = vecs[i].od;
      payload0 = pay[0];
      payload1 = pay[1];
      payload2 = pay[2];
      exp_q.push_back({vecs[i].valid, vecs[i].valid, vecs[i].sel, vecs[i].done,
                       vecs[i].valid ? pay[vecs[i].sel] : {WIDTH{1'b0}}});
      #1;
      check_out($sformatf("vec%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
